cache_refill_controller: RTL and testbench
==========================================

# cache_refill_controller

Miss-handling stage directly downstream of the two-level cache hierarchy. It accepts a request when both L1 and L2 miss (`memory_access`), fetches the 64-byte line from main memory critical-byte-first over an 8-bit handshaked bus, and streams every byte to the L1/L2 fill ports. The requested byte goes back to the requester as soon as it arrives. Write misses are write-no-allocate: a single byte is written to memory. One miss is outstanding at a time.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 8, memory/fill data width (one byte per beat)
- `OFFSET_BITS`, 6, block offset width; beats per line = 2^OFFSET_BITS = 64
- `TIMEOUT`, 255, max cycles a beat may wait for `mem_ack`; range 1..1023

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `miss_valid`  in  1  miss request (driven from `memory_access`)
- `miss_ready`  out  1  controller idle, request accepted when `miss_valid & miss_ready`
- `miss_addr`  in  ADDR_W  byte address of the miss
- `miss_rw`  in  1  0 = read, 1 = write
- `miss_wdata`  in  DATA_W  write byte
- `mem_req`  out  1  memory beat request, held until acked or timed out
- `mem_we`  out  1  1 = write beat
- `mem_addr`  out  ADDR_W  beat byte address
- `mem_wdata`  out  DATA_W  write byte
- `mem_ack`  in  1  beat complete when `mem_req & mem_ack` at rising edge
- `mem_rdata`  in  DATA_W  read byte, valid with `mem_ack`
- `fill_valid`  out  1  one byte written into L1 and L2 line buffers
- `fill_addr`  out  ADDR_W  byte address of fill byte
- `fill_data`  out  DATA_W  fill byte
- `fill_last`  out  1  line complete, caches set valid bit and tag
- `fill_abort`  out  1  line fill abandoned, caches must not set valid
- `resp_valid`  out  1  one-cycle response pulse
- `resp_data`  out  DATA_W  read byte (0 for writes)
- `resp_error`  out  1  one-cycle pulse, memory timeout
- `busy`  out  1  `!miss_ready`

## Operation
- States:
  - IDLE: `miss_ready` = 1.
  - RD: read burst.
  - WR: single write beat.
  - FIN: emits `fill_last`.
  - ERR: emits the abort and error pulses.
- Transitions:
  - IDLE→RD or IDLE→WR on accept; the request fields are latched at accept.
  - RD→FIN on the 64th ack.
  - WR→IDLE on ack.
  - RD/WR→ERR on timeout.
  - FIN→IDLE and ERR→IDLE unconditionally.
- Read beat addressing: `base = miss_addr` with offset bits cleared. Beat k uses address `base | ((off + k) mod 64)`, where `off` is the latched offset. Addresses wrap within the line and never carry into the tag/index bits.
- Beat counter: 6 bits; the burst ends after count 63 is acked.
- Each acked read beat produces, on the next cycle, a one-cycle `fill_valid` with `fill_addr` = the beat address and `fill_data` = the captured `mem_rdata`.
- Beat 0 (the critical byte) additionally produces `resp_valid` = 1 and `resp_data` = that byte in the same cycle as its `fill_valid`.
- Write: `mem_we` = 1, `mem_addr` = `miss_addr`, `mem_wdata` = `miss_wdata`. The cycle after the ack: `resp_valid` = 1, `resp_data` = 0. No fill.
- Timeout:
  - The wait counter clears on accept and on every ack, and increments each cycle `mem_req` is high without `mem_ack`.
  - When it reaches `TIMEOUT`, `mem_req` drops at the next edge and the FSM enters ERR.
  - In ERR: `resp_error` = 1, `fill_abort` = 1 (RD only), and `resp_valid` = 1 with `resp_data` = 0 only if no response was yet issued.
- `mem_ack` while `mem_req` = 0 is ignored.
- `miss_valid` while busy is ignored, with no queuing.

## Timing
- Reset values: every output is 0, including `miss_ready`. The FSM is in IDLE and `miss_ready` = 1 from the first cycle after `rst` falls.
- Reset mid-burst: all outputs return to 0 at the next edge. No `fill_last` or `fill_abort` is issued; the caches treat the partial line as never validated.
- `mem_req` rises the cycle after accept. The address is stable while `mem_req` is high and unacked; the next beat's address appears the cycle after an ack. `mem_req` stays high between beats of a burst.
- Read miss with zero-wait memory (ack every cycle), counting the accept cycle as C0:
  - C1: `mem_req` rises and beat 0 is acked.
  - C2: `resp_valid` and the first `fill_valid`.
  - C64: the 64th ack.
  - C65: the last `fill_valid` together with `fill_last` (FIN).
  - C66: `miss_ready` = 1.
- Write miss with zero-wait memory: ack at C1, `resp_valid` at C2, `miss_ready` at C3.
- If an ack and the final timeout count coincide, the ack wins.
- `resp_valid`, `fill_valid`, `fill_last`, `fill_abort` and `resp_error` are single-cycle pulses.

## Test plan
- Read miss, `miss_addr` = 0x0000_1234 (off 0x34), zero-wait memory returning `mem_rdata` = low byte of the address → `resp_data` = 0x34 at C2. Fill addresses run 0x1234..0x123F, then 0x1200..0x1233. `fill_last` at C65, `miss_ready` at C66.
- Wrap check, `miss_addr` = 0x0000_107F (off 0x3F) → beat 1 address = 0x1040, never 0x1080.
- Write miss, addr 0x0000_2000, wdata 0xA5, ack after 3 wait cycles → one beat with `mem_we` = 1 and `mem_wdata` = 0xA5. `resp_valid` = 1, `resp_data` = 0 on the cycle after the ack. No `fill_valid`.
- Timeout with `TIMEOUT` = 4: memory acks beat 0, then never acks → `resp_valid` after beat 0. After 4 unacked cycles: `fill_abort` = 1, `resp_error` = 1, no second `resp_valid`, no `fill_last`. IDLE on the next cycle.
- Busy rejection plus reset: a second `miss_valid` during a burst → ignored. Assert `rst` at beat 20 → all outputs 0 the next cycle, no `fill_last`, and `miss_ready` = 1 the cycle after `rst` falls.

Source files
------------

// File: rtl/cache_refill_controller.sv
// rtl/cache_refill_controller.sv - critical-byte-first line refill and write-no-allocate miss handler
module cache_refill_controller #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 8,
   parameter int OFFSET_BITS = 6,
   parameter int TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_valid,
   output logic              miss_ready,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              miss_rw,
   input  logic [DATA_W-1:0] miss_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fill_valid,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_last,
   output logic              fill_abort,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_error,
   output logic              busy
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FIN, S_ERR} state_t;

   localparam logic [OFFSET_BITS-1:0] BEAT_LAST = {OFFSET_BITS{1'b1}};
   localparam logic [9:0]             WAIT_LAST = 10'(TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic                   miss_ready_q, miss_ready_d;
   logic                   busy_q, busy_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
   logic                   fill_valid_q, fill_valid_d;
   logic [ADDR_W-1:0]      fill_addr_q, fill_addr_d;
   logic [DATA_W-1:0]      fill_data_q, fill_data_d;
   logic                   fill_last_q, fill_last_d;
   logic                   fill_abort_q, fill_abort_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]      resp_data_q, resp_data_d;
   logic                   resp_error_q, resp_error_d;
   logic                   resp_sent_q, resp_sent_d;
   logic [OFFSET_BITS-1:0] beat_q, beat_d;
   logic [9:0]             wait_q, wait_d;
   logic                   ack;
   logic                   timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         miss_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         fill_valid_q <= 1'b0;
         fill_addr_q  <= '0;
         fill_data_q  <= '0;
         fill_last_q  <= 1'b0;
         fill_abort_q <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
         resp_sent_q  <= 1'b0;
         beat_q       <= '0;
         wait_q       <= '0;
      end else begin
         state_q      <= state_d;
         miss_ready_q <= miss_ready_d;
         busy_q       <= busy_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         fill_valid_q <= fill_valid_d;
         fill_addr_q  <= fill_addr_d;
         fill_data_q  <= fill_data_d;
         fill_last_q  <= fill_last_d;
         fill_abort_q <= fill_abort_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
         resp_sent_q  <= resp_sent_d;
         beat_q       <= beat_d;
         wait_q       <= wait_d;
      end
   end

   // An ack in the final wait cycle wins over the timeout.
   assign ack     = mem_req_q & mem_ack;
   assign timeout = mem_req_q & ~mem_ack & (wait_q == WAIT_LAST);

   always_comb begin
      state_d      = state_q;
      miss_ready_d = miss_ready_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      fill_valid_d = 1'b0;
      fill_addr_d  = fill_addr_q;
      fill_data_d  = fill_data_q;
      fill_last_d  = 1'b0;
      fill_abort_d = 1'b0;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_error_d = 1'b0;
      resp_sent_d  = resp_sent_q;
      beat_d       = beat_q;
      wait_d       = wait_q;

      if (ack) begin
         wait_d = '0;
      end else if (mem_req_q) begin
         wait_d = wait_q + 10'd1;
      end

      case (state_q)
         S_IDLE: begin
            miss_ready_d = 1'b1;
            if (miss_valid && miss_ready_q) begin
               miss_ready_d = 1'b0;
               mem_req_d    = 1'b1;
               mem_we_d     = miss_rw;
               mem_addr_d   = miss_addr;
               mem_wdata_d  = miss_wdata;
               beat_d       = '0;
               wait_d       = '0;
               resp_sent_d  = 1'b0;
               state_d      = miss_rw ? S_WR : S_RD;
            end
         end
         S_RD: begin
            if (ack) begin
               fill_valid_d = 1'b1;
               fill_addr_d  = mem_addr_q;
               fill_data_d  = mem_rdata;
               if (beat_q == '0) begin
                  resp_valid_d = 1'b1;
                  resp_data_d  = mem_rdata;
                  resp_sent_d  = 1'b1;
               end
               beat_d = beat_q + 1'b1;
               // Offset wraps inside the line; tag/index bits are left untouched.
               mem_addr_d[OFFSET_BITS-1:0] = mem_addr_q[OFFSET_BITS-1:0] + 1'b1;
               if (beat_q == BEAT_LAST) begin
                  mem_req_d   = 1'b0;
                  fill_last_d = 1'b1;
                  state_d     = S_FIN;
               end
            end else if (timeout) begin
               mem_req_d    = 1'b0;
               fill_abort_d = 1'b1;
               resp_error_d = 1'b1;
               resp_valid_d = ~resp_sent_q;
               state_d      = S_ERR;
            end
         end
         S_WR: begin
            if (ack) begin
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_sent_d  = 1'b1;
               state_d      = S_IDLE;
            end else if (timeout) begin
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               resp_error_d = 1'b1;
               resp_valid_d = ~resp_sent_q;
               state_d      = S_ERR;
            end
         end
         S_FIN, S_ERR: begin
            miss_ready_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = ~miss_ready_d;
   end

   assign miss_ready = miss_ready_q;
   assign busy       = busy_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign fill_valid = fill_valid_q;
   assign fill_addr  = fill_addr_q;
   assign fill_data  = fill_data_q;
   assign fill_last  = fill_last_q;
   assign fill_abort = fill_abort_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_error = resp_error_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// tb/tb_cache_refill_controller.sv - directed checks of refill, wrap, write, timeout and reset behaviour
module tb_cache_refill_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_valid;
   logic        miss_ready;
   logic [31:0] miss_addr;
   logic        miss_rw;
   logic [7:0]  miss_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        fill_valid;
   logic [31:0] fill_addr;
   logic [7:0]  fill_data;
   logic        fill_last;
   logic        fill_abort;
   logic        resp_valid;
   logic [7:0]  resp_data;
   logic        resp_error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory returns the low byte of the beat address.
   assign mem_rdata = mem_addr[7:0];

   cache_refill_controller #(
      .ADDR_W(32), .DATA_W(8), .OFFSET_BITS(6), .TIMEOUT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
      .miss_rw(miss_rw), .miss_wdata(miss_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
      .fill_last(fill_last), .fill_abort(fill_abort),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, " outs"}, {miss_ready, busy, mem_req, mem_we, fill_valid, fill_last,
                          fill_abort, resp_valid, resp_error}, 32'h0);
   endtask

   initial begin
      int lasts;
      int n;
      rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_rw = 1'b0;
      miss_wdata = '0; mem_ack = 1'b0;
      tick(); tick(); tick();
      all_zero("reset");
      chk("reset mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      tick();
      chk("ready after reset", miss_ready, 1'b1);
      chk("busy after reset", busy, 1'b0);

      // Read miss at 0x1234, zero-wait memory
      miss_valid = 1'b1; miss_addr = 32'h0000_1234; miss_rw = 1'b0; mem_ack = 1'b1;
      tick();
      miss_valid = 1'b0;
      chk("rd c1 mem_req", mem_req, 1'b1);
      chk("rd c1 mem_addr", mem_addr, 32'h1234);
      chk("rd c1 busy", {miss_ready, busy}, 2'b01);
      tick();
      chk("rd c2 resp_valid", resp_valid, 1'b1);
      chk("rd c2 resp_data", resp_data, 8'h34);
      chk("rd c2 fill_valid", fill_valid, 1'b1);
      chk("rd c2 fill_addr", fill_addr, 32'h1234);
      for (int k = 1; k < 64; k++) begin
         logic [31:0] ea;
         tick();
         ea = 32'h1200 | ((32'h34 + k) & 32'h3F);
         chk("rd fill_addr", fill_addr, ea);
         chk("rd fill_data", fill_data, ea[7:0]);
         chk("rd fill_valid", fill_valid, 1'b1);
         chk("rd fill_last", fill_last, (k == 63) ? 1'b1 : 1'b0);
         chk("rd resp_valid", resp_valid, 1'b0);
      end
      mem_ack = 1'b0;
      tick();
      chk("rd c66 ready", miss_ready, 1'b1);
      chk("rd c66 pulses", {fill_valid, fill_last, mem_req}, 3'b000);

      // Wrap: offset 0x3F rolls to 0x1040, not 0x1080
      miss_valid = 1'b1; miss_addr = 32'h0000_107F; mem_ack = 1'b1;
      tick();
      miss_valid = 1'b0;
      chk("wrap beat0 addr", mem_addr, 32'h107F);
      tick();
      chk("wrap beat1 addr", mem_addr, 32'h1040);
      chk("wrap resp_data", resp_data, 8'h7F);
      lasts = 0; n = 0;
      while (!miss_ready && n < 100) begin
         tick();
         n++;
         if (fill_last) lasts++;
      end
      mem_ack = 1'b0;
      chk("wrap ready in bound", miss_ready, 1'b1);
      chk("wrap fill_last count", lasts, 1);

      // Write miss with 3 wait cycles (ack also lands on the final timeout count)
      miss_valid = 1'b1; miss_addr = 32'h0000_2000; miss_rw = 1'b1; miss_wdata = 8'hA5;
      tick();
      miss_valid = 1'b0; miss_rw = 1'b0;
      chk("wr beat", {mem_req, mem_we}, 2'b11);
      chk("wr mem_addr", mem_addr, 32'h2000);
      chk("wr mem_wdata", mem_wdata, 8'hA5);
      tick(); tick();
      chk("wr waiting", {mem_req, fill_valid, resp_valid}, 3'b100);
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("wr resp_valid", resp_valid, 1'b1);
      chk("wr resp_data", resp_data, 8'h00);
      chk("wr no fill/error", {fill_valid, resp_error, mem_req, miss_ready}, 4'b0000);
      tick();
      chk("wr ready", miss_ready, 1'b1);
      chk("wr resp pulse", resp_valid, 1'b0);

      // Timeout: beat 0 acked, then silence for 4 cycles
      miss_valid = 1'b1; miss_addr = 32'h0000_3005; mem_ack = 1'b1;
      tick();
      miss_valid = 1'b0;
      tick();
      mem_ack = 1'b0;
      chk("to resp_valid", resp_valid, 1'b1);
      chk("to resp_data", resp_data, 8'h05);
      chk("to req c2", mem_req, 1'b1);
      for (int k = 3; k <= 5; k++) begin
         tick();
         chk("to waiting", {mem_req, fill_abort, resp_error, resp_valid}, 4'b1000);
      end
      tick();
      chk("to abort", {fill_abort, resp_error}, 2'b11);
      chk("to no resp/last", {resp_valid, fill_last, mem_req}, 3'b000);
      tick();
      chk("to idle", {miss_ready, fill_abort, resp_error}, 3'b100);

      // Busy rejection followed by reset at beat 20
      miss_valid = 1'b1; miss_addr = 32'h0000_4010; mem_ack = 1'b1;
      tick();
      miss_addr = 32'h0000_5555; miss_rw = 1'b1;
      tick();
      chk("busy reject we", mem_we, 1'b0);
      chk("busy reject fill", fill_addr, 32'h4010);
      miss_valid = 1'b0; miss_rw = 1'b0;
      for (int k = 3; k <= 21; k++) tick();
      chk("beat20 addr", mem_addr, 32'h4024);
      rst = 1'b1;
      tick();
      all_zero("mid reset");
      rst = 1'b0;
      tick();
      chk("post reset ready", miss_ready, 1'b1);
      chk("post reset quiet", {fill_last, fill_abort, fill_valid, mem_req}, 4'b0000);
      tick();
      mem_ack = 1'b0;
      chk("post reset idle", {mem_req, fill_valid, resp_valid}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
